// File: rtl/shift_rotate_alu.sv
// 16-bit shift/rotate execution slice: four 4-stage log shifters (sll, srl, rol, ror)
// feed a 4:1 select in front of a registered result with a one-cycle valid strobe.
module shift_rotate_alu (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [1:0]  choice,
  input  logic [15:0] i0,
  input  logic [3:0]  shift_by,
  output logic [15:0] o,
  output logic        out_valid
);

  // Element k holds the operand after stages 0..k-1; element 4 is the engine result.
  logic [15:0] sll_s [0:4];
  logic [15:0] srl_s [0:4];
  logic [15:0] rol_s [0:4];
  logic [15:0] ror_s [0:4];

  logic [15:0] sel_res;
  logic [15:0] o_d, o_q;
  logic        out_valid_d, out_valid_q;

  assign sll_s[0] = i0;
  assign srl_s[0] = i0;
  assign rol_s[0] = i0;
  assign ror_s[0] = i0;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_stage
      localparam int unsigned SH = 1 << gi;
      assign sll_s[gi+1] = shift_by[gi] ? {sll_s[gi][15-SH:0], {SH{1'b0}}} : sll_s[gi];
      assign srl_s[gi+1] = shift_by[gi] ? {{SH{1'b0}}, srl_s[gi][15:SH]} : srl_s[gi];
      assign rol_s[gi+1] = shift_by[gi] ? {rol_s[gi][15-SH:0], rol_s[gi][15:16-SH]} : rol_s[gi];
      assign ror_s[gi+1] = shift_by[gi] ? {ror_s[gi][SH-1:0], ror_s[gi][15:SH]} : ror_s[gi];
    end
  endgenerate

  always_comb begin
    sel_res     = sll_s[4];
    o_d         = o_q;
    out_valid_d = in_valid;
    case (choice)
      2'b00:   sel_res = sll_s[4];
      2'b01:   sel_res = srl_s[4];
      2'b10:   sel_res = rol_s[4];
      default: sel_res = ror_s[4];
    endcase
    if (in_valid) o_d = sel_res;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_q         <= 16'h0000;
      out_valid_q <= 1'b0;
    end else begin
      o_q         <= o_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign o         = o_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_shift_rotate_alu.sv
// Bench for shift_rotate_alu: directed vector table, full sweep, reset/valid corner
// cases and randomized traffic against an arithmetic reference model.
module tb_shift_rotate_alu;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [1:0]  choice;
  logic [15:0] i0;
  logic [3:0]  shift_by;
  logic [15:0] o;
  logic        out_valid;

  int checks = 0;
  int passed = 0;

  typedef struct {
    logic [1:0]  choice;
    logic [3:0]  shift_by;
    logic [15:0] i0;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl [20];

  shift_rotate_alu dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .choice   (choice),
    .i0       (i0),
    .shift_by (shift_by),
    .o        (o),
    .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ref_model(input logic [1:0] ch, input logic [3:0] n,
                                            input logic [15:0] a);
    int unsigned v = a;
    int unsigned k = n;
    int unsigned r;
    case (ch)
      2'd0:    r = v << k;
      2'd1:    r = v >> k;
      2'd2:    r = (v << k) | (v >> (16 - k));
      default: r = (v >> k) | (v << (16 - k));
    endcase
    return r[15:0];
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic drive(input logic v, input logic [1:0] ch, input logic [3:0] n,
                       input logic [15:0] a);
    in_valid = v;
    choice   = ch;
    shift_by = n;
    i0       = a;
  endtask

  initial begin
    logic [15:0] exp_o;
    logic        exp_v;
    logic [15:0] e;

    tbl[0]  = '{2'd0, 4'd0,  16'h8005, 16'h8005};
    tbl[1]  = '{2'd1, 4'd0,  16'h8005, 16'h8005};
    tbl[2]  = '{2'd2, 4'd0,  16'h8005, 16'h8005};
    tbl[3]  = '{2'd3, 4'd0,  16'h8005, 16'h8005};
    tbl[4]  = '{2'd0, 4'd1,  16'h8005, 16'h000A};
    tbl[5]  = '{2'd1, 4'd1,  16'h8005, 16'h4002};
    tbl[6]  = '{2'd2, 4'd1,  16'h8005, 16'h000B};
    tbl[7]  = '{2'd3, 4'd1,  16'h8005, 16'hC002};
    tbl[8]  = '{2'd0, 4'd4,  16'h8005, 16'h0050};
    tbl[9]  = '{2'd1, 4'd4,  16'h8005, 16'h0800};
    tbl[10] = '{2'd2, 4'd4,  16'h8005, 16'h0058};
    tbl[11] = '{2'd3, 4'd4,  16'h8005, 16'h5800};
    tbl[12] = '{2'd0, 4'd8,  16'h8005, 16'h0500};
    tbl[13] = '{2'd1, 4'd8,  16'h8005, 16'h0080};
    tbl[14] = '{2'd2, 4'd8,  16'h8005, 16'h0580};
    tbl[15] = '{2'd3, 4'd8,  16'h8005, 16'h0580};
    tbl[16] = '{2'd0, 4'd15, 16'h8005, 16'h8000};
    tbl[17] = '{2'd1, 4'd15, 16'h8005, 16'h0001};
    tbl[18] = '{2'd2, 4'd15, 16'h8005, 16'hC002};
    tbl[19] = '{2'd3, 4'd15, 16'h8005, 16'h000B};

    rst = 1'b1;
    drive(1'b1, 2'd0, 4'd0, 16'hFFFF);
    #12;
    check("reset_o", o, 16'h0000);
    check("reset_valid", {15'd0, out_valid}, 16'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed table, back-to-back
    for (int t = 0; t < 20; t++) begin
      drive(1'b1, tbl[t].choice, tbl[t].shift_by, tbl[t].i0);
      @(posedge clk); #1;
      check($sformatf("tbl%0d_o", t), o, tbl[t].exp);
      check($sformatf("tbl%0d_valid", t), {15'd0, out_valid}, 16'd1);
      $display("vec %0d: choice=%0d shift_by=%0d i0=%h o=%h", t, tbl[t].choice,
               tbl[t].shift_by, tbl[t].i0, o);
    end

    // Full sweep of (shift_by, choice), one result per cycle
    for (int n = 0; n < 16; n++) begin
      for (int c = 0; c < 4; c++) begin
        drive(1'b1, 2'(c), 4'(n), 16'h8005);
        @(posedge clk); #1;
        e = ref_model(2'(c), 4'(n), 16'h8005);
        check($sformatf("sweep_n%0d_c%0d_o", n, c), o, e);
        check($sformatf("sweep_n%0d_c%0d_valid", n, c), {15'd0, out_valid}, 16'd1);
        $display("sweep: choice=%0d shift_by=%0d o=%h", c, n, o);
      end
    end

    // Dropped in_valid: valid falls, result holds
    e = o;
    drive(1'b0, 2'd0, 4'd3, 16'h1111);
    @(posedge clk); #1;
    check("gap_o_hold", o, e);
    check("gap_valid", {15'd0, out_valid}, 16'd0);
    $display("gap: out_valid=%0d o=%h", out_valid, o);
    drive(1'b1, 2'd3, 4'd2, 16'h0003);
    @(posedge clk); #1;
    check("after_gap_o", o, 16'hC000);
    check("after_gap_valid", {15'd0, out_valid}, 16'd1);

    // Asynchronous reset mid-cycle after loading 0x1234
    drive(1'b1, 2'd0, 4'd0, 16'h1234);
    @(posedge clk); #1;
    check("preload_o", o, 16'h1234);
    drive(1'b0, 2'd0, 4'd0, 16'h0000);
    #2 rst = 1'b1;
    #1;
    check("async_rst_o", o, 16'h0000);
    check("async_rst_valid", {15'd0, out_valid}, 16'd0);
    $display("async reset: o=%h out_valid=%0d", o, out_valid);
    drive(1'b1, 2'd2, 4'd4, 16'hABCD);
    @(posedge clk); #1;
    check("in_reset_o", o, 16'h0000);
    check("in_reset_valid", {15'd0, out_valid}, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("first_capture_o", o, 16'hBCDA);
    check("first_capture_valid", {15'd0, out_valid}, 16'd1);

    // Randomized traffic against the reference model
    exp_o = o;
    for (int t = 0; t < 300; t++) begin
      logic       v;
      logic [1:0] ch;
      logic [3:0] n;
      logic [15:0] a;
      v  = ($urandom_range(0, 3) != 0);
      ch = 2'($urandom_range(0, 3));
      n  = 4'($urandom_range(0, 15));
      a  = 16'($urandom);
      drive(v, ch, n, a);
      if (v) exp_o = ref_model(ch, n, a);
      exp_v = v;
      @(posedge clk); #1;
      check($sformatf("rand%0d_o", t), o, exp_o);
      check($sformatf("rand%0d_valid", t), {15'd0, out_valid}, {15'd0, exp_v});
      $display("rand %0d: v=%0d choice=%0d shift_by=%0d i0=%h o=%h", t, v, ch, n, a, o);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
